ssp_rx_fifo: RTL and testbench

Receive-side FIFO of the SSP. The SSP receive logic pushes each assembled 8-bit word into the FIFO. The processor pops words through the peripheral bus read path (PSEL with PWRITE low). SSPRXINTR flags a full FIFO so the processor drains it before data is lost, and an overrun flag records any word that was dropped.

---
 rtl/ssp_rx_fifo.sv | 76 +++++++
 tb/tb_ssp_rx_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_fifo.sv
// SSP receive FIFO: receive logic pushes assembled words, the processor pops them
// over the peripheral bus read path with first-word-fall-through data on PRDATA.
module ssp_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  output logic [WIDTH-1:0] PRDATA,
  input  logic [WIDTH-1:0] RxData,
  input  logic             RxWrite,
  output logic             RxFull,
  output logic             RxEmpty,
  output logic             RxOverrun,
  output logic             SSPRXINTR
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign RxEmpty   = (count == '0);
  assign RxFull    = (count == FULL_CNT);
  assign SSPRXINTR = RxFull;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop  = PSEL & ~PWRITE & ~RxEmpty;
  assign push = RxWrite & (~RxFull | pop);

  assign PRDATA = RxEmpty ? '0 : mem[rd_ptr];

  // Storage is not reset; a word written while CLEAR_B is low is never exposed.
  always_ff @(posedge PCLK) begin
    if (push && CLEAR_B) begin
      mem[wr_ptr] <= RxData;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      RxOverrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      // Sticky until the processor drains a word.
      if (pop) begin
        RxOverrun <= 1'b0;
      end else if (RxWrite && RxFull) begin
        RxOverrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssp_rx_fifo.sv
// Scoreboard bench for ssp_rx_fifo: directed stimulus queues expected read data,
// a negedge monitor compares PRDATA on every accepted read.
module tb_ssp_rx_fifo;

  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b1;
  logic       PSEL = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PRDATA;
  logic [7:0] RxData = 8'h00;
  logic       RxWrite = 1'b0;
  logic       RxFull;
  logic       RxEmpty;
  logic       RxOverrun;
  logic       SSPRXINTR;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  ssp_rx_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PRDATA    (PRDATA),
    .RxData    (RxData),
    .RxWrite   (RxWrite),
    .RxFull    (RxFull),
    .RxEmpty   (RxEmpty),
    .RxOverrun (RxOverrun),
    .SSPRXINTR (SSPRXINTR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read the DUT accepts must match the head of the scoreboard.
  always @(negedge PCLK) begin
    if (CLEAR_B && PSEL && !PWRITE && !RxEmpty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read got=%0h exp=none at %0t", PRDATA, $time);
      end else begin
        check("prdata", {24'h0, PRDATA}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // One bus cycle; inputs change 1 time unit after the rising edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd,
                      input bit exp_valid, input logic [7:0] exp_d);
    RxWrite = wr;
    RxData  = d;
    PSEL    = rd;
    PWRITE  = 1'b0;
    if (rd && exp_valid) exp_q.push_back(exp_d);
    if (rd && !exp_valid) begin
      #2;
      check("empty_read_prdata", {24'h0, PRDATA}, 32'h0);
    end
    @(posedge PCLK);
    #1;
    RxWrite = 1'b0;
    PSEL    = 1'b0;
  endtask

  task automatic check_flags(input string name, input bit empty, input bit full, input bit ovr);
    check({name, "_empty"}, {31'h0, RxEmpty}, {31'h0, empty});
    check({name, "_full"}, {31'h0, RxFull}, {31'h0, full});
    check({name, "_intr"}, {31'h0, SSPRXINTR}, {31'h0, full});
    check({name, "_ovr"}, {31'h0, RxOverrun}, {31'h0, ovr});
  endtask

  task automatic fill_abcd();
    step(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00);
    check_flags("fill3", 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hD4, 1'b0, 1'b0, 8'h00);
    check_flags("fill4", 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect at once.
    #7;
    CLEAR_B = 1'b0;
    #1;
    check_flags("reset", 1'b1, 1'b0, 1'b0);
    check("reset_prdata", {24'h0, PRDATA}, 32'h0);
    @(posedge PCLK);
    @(posedge PCLK);
    #1;
    CLEAR_B = 1'b1;

    // Read while empty
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check_flags("empty_read", 1'b1, 1'b0, 1'b0);

    // Fill, write access does not pop, then drain
    fill_abcd();
    PSEL = 1'b1;
    PWRITE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0;
    PWRITE = 1'b0;
    check_flags("bus_write", 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hB2);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hD4);
    check_flags("drained", 1'b1, 1'b0, 1'b0);

    // Overflow drops the word and sets the sticky flag
    fill_abcd();
    step(1'b1, 8'hE5, 1'b0, 1'b0, 8'h00);
    check_flags("overflow", 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA1);
    check_flags("ovr_cleared", 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hB2);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hD4);
    check_flags("ovr_drained", 1'b1, 1'b0, 1'b0);

    // Full with simultaneous push and pop
    fill_abcd();
    step(1'b1, 8'h55, 1'b1, 1'b1, 8'hA1);
    check_flags("full_rw", 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hB2);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hC3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'hD4);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
    check_flags("full_rw_drained", 1'b1, 1'b0, 1'b0);

    // Wrap-around with alternating push/pop
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      step(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
    end
    check_flags("wrap", 1'b1, 1'b0, 1'b0);

    // Push into empty with a concurrent read: read ignored, word held
    step(1'b1, 8'h66, 1'b1, 1'b0, 8'h00);
    check_flags("empty_rw", 1'b0, 1'b0, 1'b0);
    check("empty_rw_prdata", {24'h0, PRDATA}, 32'h66);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h66);
    check_flags("empty_rw_drained", 1'b1, 1'b0, 1'b0);

    // Reset mid-operation, with a push strobe held across a reset edge
    step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    check_flags("pre_reset", 1'b0, 1'b0, 1'b0);
    #3;
    CLEAR_B = 1'b0;
    RxWrite = 1'b1;
    RxData = 8'h99;
    #1;
    check_flags("mid_reset", 1'b1, 1'b0, 1'b0);
    check("mid_reset_prdata", {24'h0, PRDATA}, 32'h0);
    #9;
    CLEAR_B = 1'b1;
    RxWrite = 1'b0;
    #1;
    check_flags("post_reset", 1'b1, 1'b0, 1'b0);
    @(posedge PCLK);
    #1;
    step(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    check_flags("post_reset_drained", 1'b1, 1'b0, 1'b0);

    @(posedge PCLK);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
